// File: rtl/cache_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_wb_arbiter_if
// Signal bundle for cache_wb_arbiter: two Wishbone master ports (icache = port
// 0, dcache = port 1) and the shared memory-side Wishbone bus. Signal names
// keep their i_/o_ prefixes as seen from the arbiter.
//   modport slave  : arbiter side (takes i_*, drives o_*)
//   modport master : environment side (drives i_*, takes o_*)
// Parameters: AW address width, DW data width (select width DW/8).
// ---------------------------------------------------------------------------
interface cache_wb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // icache port
    logic          i_ic_cyc, i_ic_stb, i_ic_we;
    logic [AW-1:0] i_ic_addr;
    logic [DW-1:0] i_ic_data;
    logic [DW/8-1:0] i_ic_sel;
    logic          o_ic_stall, o_ic_ack, o_ic_err;
    logic [DW-1:0] o_ic_data;
    // dcache port
    logic          i_dc_cyc, i_dc_stb, i_dc_we;
    logic [AW-1:0] i_dc_addr;
    logic [DW-1:0] i_dc_data;
    logic [DW/8-1:0] i_dc_sel;
    logic          o_dc_stall, o_dc_ack, o_dc_err;
    logic [DW-1:0] o_dc_data;
    // memory bus
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic          i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0] i_wb_data;
    // current owner, one-hot
    logic [1:0]    o_grant;

    modport slave (
        input  i_ic_cyc, i_ic_stb, i_ic_we, i_ic_addr, i_ic_data, i_ic_sel,
        output o_ic_stall, o_ic_ack, o_ic_err, o_ic_data,
        input  i_dc_cyc, i_dc_stb, i_dc_we, i_dc_addr, i_dc_data, i_dc_sel,
        output o_dc_stall, o_dc_ack, o_dc_err, o_dc_data,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_grant
    );

    modport master (
        output i_ic_cyc, i_ic_stb, i_ic_we, i_ic_addr, i_ic_data, i_ic_sel,
        input  o_ic_stall, o_ic_ack, o_ic_err, o_ic_data,
        output i_dc_cyc, i_dc_stb, i_dc_we, i_dc_addr, i_dc_data, i_dc_sel,
        input  o_dc_stall, o_dc_ack, o_dc_err, o_dc_data,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_grant
    );
endinterface

// File: rtl/cache_wb_arbiter.sv
// ---------------------------------------------------------------------------
// cache_wb_arbiter
// Two-master Wishbone arbiter: icache (port 0) and dcache (port 1) share one
// memory bus. Ownership is granted from IDLE one cycle after a request, held
// until the owner drops cyc, and always followed by one dead IDLE cycle.
// Simultaneous requests go to the port not served last (dcache after reset).
//
// Ports:
//   i_clk      clock (rising edge)
//   i_reset_n  asynchronous active-low reset
//   io_bus     cache_wb_arbiter_if.slave: ic/dc master ports, memory bus,
//              o_grant (bit0 icache, bit1 dcache, 00 when idle)
// Parameters: AW, DW, TIMEOUT (watchdog limit, >= 2)
//
// Optional feature, macro ARB_WATCHDOG_EN: a per-transaction watchdog aborts
// an owner that sees no ack/err for TIMEOUT-1 owned cycles. The aborted port
// receives a one-cycle err and is locked out until it drops cyc once.
// ---------------------------------------------------------------------------
module cache_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    cache_wb_arbiter_if.slave    io_bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_IC = 2'd1, OWN_DC = 2'd2} state_t;

    state_t          r_state;
    logic [1:0]      r_grant;
    logic            r_last_dc;   // 1: dcache was served last
    logic            w_abort;
    logic            w_ic_blk, w_dc_blk;
    logic            w_ic_req, w_dc_req;
    logic            w_own_ic, w_own_dc, w_live;
    logic            w_stb, w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_sel;

    assign w_ic_req = io_bus.i_ic_cyc && !w_ic_blk;
    assign w_dc_req = io_bus.i_dc_cyc && !w_dc_blk;

    // Arbitration FSM; o_grant is a registered copy of the owner.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_last_dc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // On a tie dcache wins unless it was served last.
                    if (w_dc_req && (!w_ic_req || !r_last_dc)) begin
                        r_state <= OWN_DC;
                        r_grant <= 2'b10;
                    end else if (w_ic_req) begin
                        r_state <= OWN_IC;
                        r_grant <= 2'b01;
                    end
                end
                OWN_IC: if (!io_bus.i_ic_cyc || w_abort) begin
                    r_state   <= IDLE;
                    r_grant   <= 2'b00;
                    r_last_dc <= 1'b0;
                end
                OWN_DC: if (!io_bus.i_dc_cyc || w_abort) begin
                    r_state   <= IDLE;
                    r_grant   <= 2'b00;
                    r_last_dc <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wd;
    logic          r_ic_blk, r_dc_blk;

    // r_wd counts owned cycles already elapsed without ack/err, so the
    // abort fires in the cycle that brings the count to TIMEOUT-1.
    assign w_abort = (r_state != IDLE) && !io_bus.i_wb_ack && !io_bus.i_wb_err &&
                     (r_wd == CW'(TIMEOUT - 2));
    assign w_ic_blk = r_ic_blk;
    assign w_dc_blk = r_dc_blk;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wd     <= '0;
            r_ic_blk <= 1'b0;
            r_dc_blk <= 1'b0;
        end else begin
            if (r_state == IDLE || io_bus.i_wb_ack || io_bus.i_wb_err)
                r_wd <= '0;
            else
                r_wd <= r_wd + 1'b1;
            // Lock-out clears once cyc is seen low; only set if the aborted
            // owner is still holding cyc.
            if (!io_bus.i_ic_cyc)                         r_ic_blk <= 1'b0;
            else if (w_abort && r_state == OWN_IC)        r_ic_blk <= 1'b1;
            if (!io_bus.i_dc_cyc)                         r_dc_blk <= 1'b0;
            else if (w_abort && r_state == OWN_DC)        r_dc_blk <= 1'b1;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
    assign w_abort  = 1'b0;
    assign w_ic_blk = 1'b0;
    assign w_dc_blk = 1'b0;
`endif

    assign w_own_ic = r_grant[0];
    assign w_own_dc = r_grant[1];
    // Bus cycle is dropped in the abort cycle itself, not one edge later.
    assign w_live   = (r_grant != 2'b00) && !w_abort;

    // Owner's request mirrored onto the memory bus.
    always_comb begin
        w_stb  = 1'b0;
        w_we   = 1'b0;
        w_addr = '0;
        w_data = '0;
        w_sel  = '0;
        if (w_own_ic) begin
            w_stb  = io_bus.i_ic_stb;
            w_we   = io_bus.i_ic_we;
            w_addr = io_bus.i_ic_addr;
            w_data = io_bus.i_ic_data;
            w_sel  = io_bus.i_ic_sel;
        end else if (w_own_dc) begin
            w_stb  = io_bus.i_dc_stb;
            w_we   = io_bus.i_dc_we;
            w_addr = io_bus.i_dc_addr;
            w_data = io_bus.i_dc_data;
            w_sel  = io_bus.i_dc_sel;
        end
    end

    assign io_bus.o_wb_cyc  = w_live;
    assign io_bus.o_wb_stb  = w_live && w_stb;
    assign io_bus.o_wb_we   = w_we;
    assign io_bus.o_wb_addr = w_addr;
    assign io_bus.o_wb_data = w_data;
    assign io_bus.o_wb_sel  = w_sel;
    assign io_bus.o_grant   = r_grant;

    // Responses: owner sees the memory bus, everyone else is stalled.
    assign io_bus.o_ic_stall = w_own_ic ? io_bus.i_wb_stall : 1'b1;
    assign io_bus.o_ic_ack   = w_own_ic && io_bus.i_wb_ack;
    assign io_bus.o_ic_err   = w_own_ic && (io_bus.i_wb_err || w_abort);
    assign io_bus.o_ic_data  = w_own_ic ? io_bus.i_wb_data : '0;
    assign io_bus.o_dc_stall = w_own_dc ? io_bus.i_wb_stall : 1'b1;
    assign io_bus.o_dc_ack   = w_own_dc && io_bus.i_wb_ack;
    assign io_bus.o_dc_err   = w_own_dc && (io_bus.i_wb_err || w_abort);
    assign io_bus.o_dc_data  = w_own_dc ? io_bus.i_wb_data : '0;
endmodule

// File: tb/tb_cache_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_wb_arbiter
// Directed scenarios for reset, arbitration order, read burst, error
// forwarding, watchdog (when ARB_WATCHDOG_EN is defined) and mid-burst reset,
// followed by a randomized run checked against a cycle-level reference model
// that tracks owner, last-served port, lock-outs and owned-cycle age.
// ---------------------------------------------------------------------------
module tb_cache_wb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    cache_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    cache_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_ic_cyc = 0; bus.i_ic_stb = 0; bus.i_ic_we = 0;
        bus.i_ic_addr = '0; bus.i_ic_data = '0; bus.i_ic_sel = '0;
        bus.i_dc_cyc = 0; bus.i_dc_stb = 0; bus.i_dc_we = 0;
        bus.i_dc_addr = '0; bus.i_dc_data = '0; bus.i_dc_sel = '0;
        bus.i_wb_stall = 0; bus.i_wb_ack = 0; bus.i_wb_err = 0; bus.i_wb_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Idle after reset: no grant, no bus cycle, both ports stalled.
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.o_grant !== 2'b00 || bus.o_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: grant=%b wb_cyc=%b, expected 00 0", bus.o_grant, bus.o_wb_cyc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (bus.o_grant !== 2'b00 || bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 ||
                bus.o_ic_stall !== 1'b1 || bus.o_dc_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: grant=%b cyc=%b stb=%b stalls=%b%b, expected 00 0 0 11",
                         k, bus.o_grant, bus.o_wb_cyc, bus.o_wb_stb, bus.o_ic_stall, bus.o_dc_stall);
            end
        end
    endtask

    // Tie after reset goes to dcache; one dead cycle before icache gets it.
    task automatic test_arbitration();
        bus.i_ic_cyc = 1; bus.i_dc_cyc = 1;
        #1;
        n_checks++;
        if (bus.o_grant !== 2'b00 || bus.o_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_req_cycle: grant=%b cyc=%b, expected 00 0", bus.o_grant, bus.o_wb_cyc);
        end
        tick();
        n_checks++;
        if (bus.o_grant !== 2'b10 || bus.o_wb_cyc !== 1'b1 || bus.o_ic_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_tie: grant=%b cyc=%b ic_stall=%b, expected 10 1 1",
                     bus.o_grant, bus.o_wb_cyc, bus.o_ic_stall);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bus.o_grant !== 2'b10) begin
                n_fail++;
                $display("FAIL arb_hold c%0d: grant=%b expected 10", k, bus.o_grant);
            end
        end
        bus.i_dc_cyc = 0;
        tick();
        n_checks++;
        if (bus.o_grant !== 2'b00 || bus.o_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_dead_cycle: grant=%b cyc=%b, expected 00 0", bus.o_grant, bus.o_wb_cyc);
        end
        tick();
        n_checks++;
        if (bus.o_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL arb_second: grant=%b expected 01", bus.o_grant);
        end
        bus.i_ic_cyc = 0;
        tick();
    endtask

    // Icache 4-beat read; acks at 3,5,7,9 cycles after grant.
    task automatic test_read_burst();
        logic [DW-1:0] beats [4];
        logic [AW-1:0] a;
        int            bi;
        logic          e_ack;
        for (int i = 0; i < 4; i++) beats[i] = $urandom;
        a = $urandom;
        bus.i_ic_cyc = 1; bus.i_ic_stb = 1; bus.i_ic_addr = a; bus.i_ic_sel = '1;
        tick();
        bi = 0;
        for (int k = 0; k <= 10; k++) begin
            e_ack = (k == 3 || k == 5 || k == 7 || k == 9);
            bus.i_wb_ack  = e_ack;
            bus.i_wb_data = e_ack ? beats[bi] : DW'($urandom);
            #1;
            n_checks++;
            if (bus.o_ic_ack !== e_ack || bus.o_dc_ack !== 1'b0 ||
                (e_ack && bus.o_ic_data !== beats[bi]) || bus.o_wb_addr !== a) begin
                n_fail++;
                $display("FAIL read_burst k%0d: ic_ack=%b dc_ack=%b data=%h addr=%h, expected %b 0 %h %h",
                         k, bus.o_ic_ack, bus.o_dc_ack, bus.o_ic_data, bus.o_wb_addr,
                         e_ack, e_ack ? beats[bi] : bus.o_ic_data, a);
            end
            if (e_ack) bi++;
            tick();
        end
        bus.i_wb_ack = 0;
        bus.i_ic_cyc = 0; bus.i_ic_stb = 0;
        tick();
    endtask

    // Dcache write, err on second beat: forwarded once, ownership kept.
    task automatic test_dc_error();
        logic e_ack, e_err;
        bus.i_dc_cyc = 1; bus.i_dc_stb = 1; bus.i_dc_we = 1; bus.i_dc_data = $urandom;
        tick();
        for (int k = 0; k < 5; k++) begin
            e_ack = (k == 1);
            e_err = (k == 2);
            bus.i_wb_ack = e_ack;
            bus.i_wb_err = e_err;
            #1;
            n_checks++;
            if (bus.o_dc_err !== e_err || bus.o_dc_ack !== e_ack || bus.o_grant !== 2'b10 ||
                bus.o_wb_we !== 1'b1 || bus.o_ic_err !== 1'b0) begin
                n_fail++;
                $display("FAIL dc_error k%0d: err=%b ack=%b grant=%b we=%b ic_err=%b, expected %b %b 10 1 0",
                         k, bus.o_dc_err, bus.o_dc_ack, bus.o_grant, bus.o_wb_we, bus.o_ic_err, e_err, e_ack);
            end
            tick();
        end
        bus.i_wb_ack = 0; bus.i_wb_err = 0;
        bus.i_dc_cyc = 0; bus.i_dc_stb = 0; bus.i_dc_we = 0;
        tick();
        n_checks++;
        if (bus.o_grant !== 2'b00) begin
            n_fail++;
            $display("FAIL dc_error_release: grant=%b expected 00", bus.o_grant);
        end
    endtask

`ifdef ARB_WATCHDOG_EN
    // Owner never acked: err and cyc drop on the 7th owned cycle, then lock-out.
    task automatic test_watchdog();
        bus.i_ic_cyc = 1; bus.i_ic_stb = 1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            n_checks++;
            if (bus.o_ic_err !== (k == 7) || bus.o_wb_cyc !== (k != 7) || bus.o_grant !== 2'b01) begin
                n_fail++;
                $display("FAIL watchdog c%0d: err=%b cyc=%b grant=%b, expected %b %b 01",
                         k, bus.o_ic_err, bus.o_wb_cyc, bus.o_grant, (k == 7), (k != 7));
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.o_grant !== 2'b00 || bus.o_ic_err !== 1'b0) begin
                n_fail++;
                $display("FAIL watchdog_block c%0d: grant=%b err=%b, expected 00 0", k, bus.o_grant, bus.o_ic_err);
            end
            tick();
        end
        bus.i_ic_cyc = 0;
        tick();
        bus.i_ic_cyc = 1;
        tick();
        n_checks++;
        if (bus.o_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL watchdog_unblock: grant=%b expected 01", bus.o_grant);
        end
        bus.i_ic_cyc = 0; bus.i_ic_stb = 0;
        tick();
    endtask
`else
    // Without the watchdog, an un-acked owner keeps the bus indefinitely.
    task automatic test_no_watchdog();
        bus.i_ic_cyc = 1; bus.i_ic_stb = 1;
        tick();
        for (int k = 0; k < 30; k++) begin
            n_checks++;
            if (bus.o_ic_err !== 1'b0 || bus.o_wb_cyc !== 1'b1 || bus.o_grant !== 2'b01) begin
                n_fail++;
                $display("FAIL no_watchdog c%0d: err=%b cyc=%b grant=%b, expected 0 1 01",
                         k, bus.o_ic_err, bus.o_wb_cyc, bus.o_grant);
            end
            tick();
        end
        bus.i_ic_cyc = 0; bus.i_ic_stb = 0;
        tick();
    endtask
`endif

    // Reset mid-burst drops the bus at once and restores the dcache-first tie.
    task automatic test_reset_mid();
        bus.i_ic_cyc = 1; bus.i_ic_stb = 1;
        tick();
        bus.i_wb_ack = 1;
        #1;
        n_checks++;
        if (bus.o_ic_ack !== 1'b1 || bus.o_wb_cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: ack=%b cyc=%b, expected 1 1", bus.o_ic_ack, bus.o_wb_cyc);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_wb_cyc !== 1'b0 || bus.o_grant !== 2'b00 || bus.o_ic_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: cyc=%b grant=%b ack=%b, expected 0 00 0",
                     bus.o_wb_cyc, bus.o_grant, bus.o_ic_ack);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        bus.i_ic_cyc = 1; bus.i_dc_cyc = 1;
        tick();
        n_checks++;
        if (bus.o_grant !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_tie: grant=%b expected 10", bus.o_grant);
        end
        bus.i_ic_cyc = 0; bus.i_dc_cyc = 0;
        tick();
    endtask

    // Randomized traffic against a reference model.
    task automatic test_random();
        int   own, last, age;
        bit   blk_ic, blk_dc;
        int   n_own, n_last, n_age;
        bit   n_blk_ic, n_blk_dc;
        bit   hit, live, own_cyc;
        logic [1:0] e_grant;
        logic [AW+DW+SW+1:0] e_mir, g_mir;
        logic [2:0] e_ic, e_dc;
        logic [DW-1:0] e_data, g_data;
        do_reset();
        own = 0; last = 1; age = 0; blk_ic = 0; blk_dc = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.i_ic_cyc = !bus.i_ic_cyc;
            if ($urandom_range(0, 5) == 0) bus.i_dc_cyc = !bus.i_dc_cyc;
            bus.i_ic_stb = 1'($urandom_range(0, 1)); bus.i_ic_we = 1'($urandom_range(0, 1));
            bus.i_ic_addr = $urandom; bus.i_ic_data = $urandom; bus.i_ic_sel = SW'($urandom);
            bus.i_dc_stb = 1'($urandom_range(0, 1)); bus.i_dc_we = 1'($urandom_range(0, 1));
            bus.i_dc_addr = $urandom; bus.i_dc_data = $urandom; bus.i_dc_sel = SW'($urandom);
            bus.i_wb_stall = 1'($urandom_range(0, 1));
            bus.i_wb_ack = ($urandom_range(0, 5) == 0);
            bus.i_wb_err = ($urandom_range(0, 24) == 0);
            bus.i_wb_data = $urandom;
            #1;
            hit  = WD && own != 0 && !bus.i_wb_ack && !bus.i_wb_err && (age + 1 >= TO - 1);
            live = (own != 0) && !hit;
            e_grant = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
            n_checks++;
            if (bus.o_grant !== e_grant || bus.o_wb_cyc !== live) begin
                n_fail++;
                $display("FAIL rand_grant c%0d: grant=%b cyc=%b, expected %b %b",
                         c, bus.o_grant, bus.o_wb_cyc, e_grant, live);
            end
            if (live) begin
                e_mir = (own == 1) ?
                    {bus.i_ic_stb, bus.i_ic_we, bus.i_ic_addr, bus.i_ic_data, bus.i_ic_sel} :
                    {bus.i_dc_stb, bus.i_dc_we, bus.i_dc_addr, bus.i_dc_data, bus.i_dc_sel};
                g_mir = {bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel};
                n_checks++;
                if (g_mir !== e_mir) begin
                    n_fail++;
                    $display("FAIL rand_mirror c%0d: bus=%h expected %h", c, g_mir, e_mir);
                end
            end
            e_ic = (own == 1) ? {bus.i_wb_stall, bus.i_wb_ack, bus.i_wb_err | hit} : 3'b100;
            e_dc = (own == 2) ? {bus.i_wb_stall, bus.i_wb_ack, bus.i_wb_err | hit} : 3'b100;
            n_checks++;
            if ({bus.o_ic_stall, bus.o_ic_ack, bus.o_ic_err} !== e_ic ||
                {bus.o_dc_stall, bus.o_dc_ack, bus.o_dc_err} !== e_dc) begin
                n_fail++;
                $display("FAIL rand_resp c%0d: ic=%b dc=%b (stall,ack,err), expected %b %b", c,
                         {bus.o_ic_stall, bus.o_ic_ack, bus.o_ic_err},
                         {bus.o_dc_stall, bus.o_dc_ack, bus.o_dc_err}, e_ic, e_dc);
            end
            if (own != 0) begin
                e_data = bus.i_wb_data;
                g_data = (own == 1) ? bus.o_ic_data : bus.o_dc_data;
                n_checks++;
                if (g_data !== e_data || ((own == 1) ? bus.o_dc_data : bus.o_ic_data) !== '0) begin
                    n_fail++;
                    $display("FAIL rand_data c%0d: owner=%h other=%h, expected %h 0", c, g_data,
                             (own == 1) ? bus.o_dc_data : bus.o_ic_data, e_data);
                end
            end
            // next model state
            n_own = own; n_last = last; n_blk_ic = blk_ic; n_blk_dc = blk_dc;
            if (own == 0) begin
                if (bus.i_ic_cyc && !blk_ic && bus.i_dc_cyc && !blk_dc) n_own = (last == 1) ? 2 : 1;
                else if (bus.i_ic_cyc && !blk_ic)                       n_own = 1;
                else if (bus.i_dc_cyc && !blk_dc)                       n_own = 2;
            end else begin
                own_cyc = (own == 1) ? bus.i_ic_cyc : bus.i_dc_cyc;
                if (!own_cyc || hit) begin
                    n_own = 0;
                    n_last = own;
                    if (hit && own_cyc) begin
                        if (own == 1) n_blk_ic = 1; else n_blk_dc = 1;
                    end
                end
            end
            if (!bus.i_ic_cyc) n_blk_ic = 0;
            if (!bus.i_dc_cyc) n_blk_dc = 0;
            n_age = (own == 0 || bus.i_wb_ack || bus.i_wb_err) ? 0 : age + 1;
            tick();
            own = n_own; last = n_last; age = n_age; blk_ic = n_blk_ic; blk_dc = n_blk_dc;
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_arbitration();
        test_read_burst();
        test_dc_error();
`ifdef ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
